// File: rtl/c_skip_pkg.sv
// Shared definitions for the sequential 26-bit carry-skip subtractor:
// FSM state encoding and the fixed 16/8/2 segment boundaries.
package c_skip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S0,
    S1,
    S2,
    DONE
  } state_e;

  localparam int SEG0_LO   = 1;
  localparam int SEG0_HI   = 16;
  localparam int SEG1_LO   = 17;
  localparam int SEG1_HI   = 24;
  localparam int SEG2_LO   = 25;
  localparam int SEG2_HI   = 26;
  localparam int SEG_MAX_W = 16;

  localparam int SEG0_W = SEG0_HI - SEG0_LO + 1;
  localparam int SEG1_W = SEG1_HI - SEG1_LO + 1;
  localparam int SEG2_W = SEG2_HI - SEG2_LO + 1;

endpackage

// File: rtl/c_skip_sub_seg.sv
// Combinational carry-skip segment subtractor: diff = a + ~b + ~borrow_in.
// The carry chain ripples inside each SKIP-bit block; a block whose bits all
// propagate forwards its incoming carry directly to the next block.
// A narrower segment fed with zero-extended operands finds its own borrow-out
// in diff[segment width], since every bit above the segment propagates.
module c_skip_sub_seg
  import c_skip_pkg::*;
#(
  parameter int WIDTH = SEG_MAX_W,
  parameter int SKIP  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int NBLK = WIDTH / SKIP;

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   carry;

  // Propagate/generate, blockwise ripple with skip bypass, then the sum bits.
  always_comb begin
    nb       = ~b;
    p        = a ^ nb;
    g        = a & nb;
    carry    = '0;
    carry[0] = ~borrow_in;
    for (int blk = 0; blk < NBLK; blk++) begin
      for (int i = 0; i < SKIP; i++) begin
        carry[blk*SKIP+i+1] = g[blk*SKIP+i] | (p[blk*SKIP+i] & carry[blk*SKIP+i]);
      end
      if (&p[blk*SKIP +: SKIP]) begin
        carry[(blk+1)*SKIP] = carry[blk*SKIP];
      end
    end
    // Any bits left over when SKIP does not divide WIDTH simply ripple.
    for (int i = NBLK * SKIP; i < WIDTH; i++) begin
      carry[i+1] = g[i] | (p[i] & carry[i]);
    end
    diff       = p ^ carry[WIDTH-1:0];
    borrow_out = ~carry[WIDTH];
  end

endmodule

// File: rtl/c_skip_sub_26bit_seq.sv
// Sequential 26-bit carry-skip subtractor: D = A - B - bin with borrow-out.
// One shared segment datapath evaluates bits 16:1, 24:17 and 26:25 on three
// consecutive cycles, chaining the borrow through a register, behind a
// valid/ready handshake on both sides.
// Optional feature macro: C_SKIP_SUB_OVF_EN adds the registered signed
// overflow output ovf.
module c_skip_sub_26bit_seq
  import c_skip_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int SKIP  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:1] A,
  input  logic [WIDTH:1] B,
  input  logic           bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:1] D,
  output logic           bout
`ifdef C_SKIP_SUB_OVF_EN
  ,
  output logic           ovf
`endif
);

  state_e               state_q, state_d;
  logic [WIDTH:1]       a_q, a_d;
  logic [WIDTH:1]       b_q, b_d;
  logic                 borrow_q, borrow_d;
  logic [WIDTH:1]       res_q, res_d;
  logic                 bout_q, bout_d;
  logic                 out_valid_q, out_valid_d;
`ifdef C_SKIP_SUB_OVF_EN
  logic                 ovf_q, ovf_d;
`endif

  logic [SEG_MAX_W-1:0] seg_a;
  logic [SEG_MAX_W-1:0] seg_b;
  logic [SEG_MAX_W-1:0] seg_diff;
  logic                 seg_bout_full;
  logic                 seg_borrow;
  logic                 accept;

  assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // Select the active segment's operands (zero-extended) and its borrow-out.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    seg_a      = '0;
    seg_b      = '0;
    seg_borrow = seg_bout_full;
    unique case (state_q)
      S1: begin
        seg_a[SEG1_W-1:0] = a_q[SEG1_HI:SEG1_LO];
        seg_b[SEG1_W-1:0] = b_q[SEG1_HI:SEG1_LO];
        seg_borrow        = seg_diff[SEG1_W];
      end
      S2: begin
        seg_a[SEG2_W-1:0] = a_q[SEG2_HI:SEG2_LO];
        seg_b[SEG2_W-1:0] = b_q[SEG2_HI:SEG2_LO];
        seg_borrow        = seg_diff[SEG2_W];
      end
      default: begin
        seg_a = a_q[SEG0_HI:SEG0_LO];
        seg_b = b_q[SEG0_HI:SEG0_LO];
      end
    endcase
  end

  c_skip_sub_seg #(
    .WIDTH (SEG_MAX_W),
    .SKIP  (SKIP)
  ) u_seg (
    .a          (seg_a),
    .b          (seg_b),
    .borrow_in  (borrow_q),
    .diff       (seg_diff),
    .borrow_out (seg_bout_full)
  );

  // Next-state, operand latch and segment-by-segment result update.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    borrow_d    = borrow_q;
    res_d       = res_q;
    bout_d      = bout_q;
    out_valid_d = out_valid_q;
`ifdef C_SKIP_SUB_OVF_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = A;
          b_d      = B;
          borrow_d = bin;
          state_d  = S0;
        end
      end
      S0: begin
        res_d[SEG0_HI:SEG0_LO] = seg_diff[SEG0_W-1:0];
        borrow_d               = seg_borrow;
        state_d                = S1;
      end
      S1: begin
        res_d[SEG1_HI:SEG1_LO] = seg_diff[SEG1_W-1:0];
        borrow_d               = seg_borrow;
        state_d                = S2;
      end
      S2: begin
        res_d[SEG2_HI:SEG2_LO] = seg_diff[SEG2_W-1:0];
        bout_d                 = seg_borrow;
        out_valid_d            = 1'b1;
`ifdef C_SKIP_SUB_OVF_EN
        ovf_d = (a_q[WIDTH] ^ b_q[WIDTH]) & (seg_diff[SEG2_W-1] ^ a_q[WIDTH]);
`endif
        state_d                = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            a_d      = A;
            b_d      = B;
            borrow_d = bin;
            state_d  = S0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q     <= IDLE;
      // NOTE: operand registers are reset too, so an aborted operation leaves nothing behind.
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      res_q       <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef C_SKIP_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      borrow_q    <= borrow_d;
      res_q       <= res_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
`ifdef C_SKIP_SUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign D         = res_q;
  assign bout      = bout_q;
  assign out_valid = out_valid_q;
`ifdef C_SKIP_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
